// File: rtl/gol_scheduler.sv
// gol_scheduler: 8x8 toroidal Game-of-Life sequencer feeding one cell per cycle to an external evaluator.
module gol_scheduler #(
  parameter int GENS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [2:0]        load_row,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic [GENS_W-1:0] gens,
  input  logic [2:0]        rd_row,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic [GENS_W-1:0] gen_count,
  output logic [7:0]        pix_nbr,
  output logic              pix_self,
  input  logic              pix_next
);
  typedef enum logic [1:0] {IDLE, EVAL, COMMIT, FIN} state_t;
  state_t            r_state;
  logic [7:0]        r_cur [8];
  logic [7:0]        r_nxt [8];
  logic [5:0]        r_idx;
  logic [GENS_W-1:0] r_gens;
  logic [GENS_W-1:0] r_gen;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        w_row, w_col, w_rm, w_rp, w_cm, w_cp;
  logic [GENS_W-1:0] w_gen_inc;
  logic              w_eval;
  assign w_row     = r_idx[5:3];
  assign w_col     = r_idx[2:0];
  assign w_rm      = w_row - 3'd1;
  assign w_rp      = w_row + 3'd1;
  assign w_cm      = w_col - 3'd1;
  assign w_cp      = w_col + 3'd1;
  assign w_gen_inc = r_gen + 1'b1;
  assign w_eval    = r_state == EVAL;
  assign rd_data   = r_cur[rd_row];
  assign busy      = r_busy;
  assign done      = r_done;
  assign gen_count = r_gen;
  assign pix_self  = w_eval & r_cur[w_row][w_col];
  // 3-bit row/column arithmetic wraps naturally, giving the torus
  assign pix_nbr   = w_eval ? {r_cur[w_rp][w_cp], r_cur[w_rp][w_col], r_cur[w_rp][w_cm],
                               r_cur[w_row][w_cp], r_cur[w_row][w_cm],
                               r_cur[w_rm][w_cp], r_cur[w_rm][w_col], r_cur[w_rm][w_cm]} : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cur   <= '{default: 8'd0};
      r_nxt   <= '{default: 8'd0};
      r_idx   <= '0;
      r_gens  <= '0;
      r_gen   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_en) r_cur[load_row] <= load_data;
          if (start) begin
            r_gens  <= gens;
            r_gen   <= '0;
            r_idx   <= '0;
            r_state <= (gens != '0) ? EVAL : FIN;
            r_busy  <= gens != '0;
            r_done  <= gens == '0;
          end
        end
        EVAL: begin
          r_nxt[w_row][w_col] <= pix_next;
          r_idx <= r_idx + 6'd1;
          if (r_idx == 6'd63) r_state <= COMMIT;
        end
        COMMIT: begin
          r_cur   <= r_nxt;
          r_gen   <= w_gen_inc;
          r_idx   <= '0;
          r_state <= (w_gen_inc == r_gens) ? FIN : EVAL;
          r_busy  <= w_gen_inc != r_gens;
          r_done  <= w_gen_inc == r_gens;
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gol_scheduler.sv
// tb_gol_scheduler: randomized scoreboard bench with a B3/S23 evaluator and a torus reference model.
`timescale 1ns/1ps
module tb_gol_scheduler;
  logic       clk = 1'b0, rst = 1'b1, load_en = 1'b0, start = 1'b0;
  logic [2:0] load_row = '0, rd_row = '0;
  logic [7:0] load_data = '0, gens = '0;
  logic [7:0] rd_data, gen_count, pix_nbr;
  logic       busy, done, pix_self, pix_next;
  typedef struct {int t; logic [63:0] g; int gc; int bc;} exp_t;
  exp_t        q[$];
  int          errors = 0, checks = 0, cyc = 0, n_checked = 0, n_done = 0, busy_cnt = 0;
  logic [63:0] m = '0;
  gol_scheduler #(.GENS_W(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .start(start), .gens(gens), .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done),
    .gen_count(gen_count), .pix_nbr(pix_nbr), .pix_self(pix_self), .pix_next(pix_next)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pix_next = ($countones(pix_nbr) == 3) || (pix_self && $countones(pix_nbr) == 2);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  function automatic logic [63:0] step(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) k += int'(g[((r + dr + 8) % 8) * 8 + (c + dc + 8) % 8]);
        n[r * 8 + c] = (k == 3) || (g[r * 8 + c] && k == 2);
      end
    return n;
  endfunction
  task automatic check_rows(input string nm, input logic [63:0] g);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      chk($sformatf("%s_row%0d", nm, r), 64'(rd_data), 64'(g[r * 8 +: 8]));
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else begin
        if (busy) busy_cnt++;
        if (done) begin
          n_done++;
          chk("done_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.t));
            chk("gen_count", 64'(gen_count), 64'(e.gc));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.bc));
            chk("pix_idle", {55'd0, pix_self, pix_nbr}, 64'd0);
            check_rows("grid", e.g);
            chk("gen_count_hold", 64'(gen_count), 64'(e.gc));
            n_checked++;
          end
          busy_cnt = 0;
        end
      end
    end
  end
  task automatic load(input int r, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_row = 3'(r); load_data = d;
    m[r * 8 +: 8] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m = '0;
  endtask
  task automatic issue(input int g, input bit ld, input int lr, input logic [7:0] ld_d, output int tgt);
    exp_t e;
    @(negedge clk);
    if (ld) begin
      load_en = 1'b1; load_row = 3'(lr); load_data = ld_d;
      m[lr * 8 +: 8] = ld_d;
    end
    start = 1'b1; gens = 8'(g);
    e.t = cyc + 1 + 65 * g;
    for (int i = 0; i < g; i++) m = step(m);
    e.g = m; e.gc = g; e.bc = 65 * g;
    q.push_back(e);
    tgt = n_checked + 1;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
  endtask
  task automatic run(input int g, input bit ld, input int lr, input logic [7:0] ld_d, input bit poke);
    int tgt;
    issue(g, ld, lr, ld_d, tgt);
    if (poke) begin
      repeat (5) @(negedge clk);
      repeat (10) begin
        start = 1'b1; gens = 8'($urandom_range(0, 255));
        load_en = 1'b1; load_row = 3'($urandom_range(0, 7)); load_data = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      start = 1'b0; load_en = 1'b0;
    end
    for (int i = 0; i < 65 * g + 40 && n_checked < tgt; i++) @(negedge clk);
    chk("run_completed", 64'(n_checked >= tgt), 64'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin : stimulus
    int tgt, nd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_gen_count", 64'(gen_count), 64'd0);
    chk("rst_pix", {55'd0, pix_self, pix_nbr}, 64'd0);
    check_rows("rst", '0);
    load(3, 8'h1C);
    run(1, 0, 0, 8'h00, 0);
    reset_dut();
    load(1, 8'h06); load(2, 8'h06);
    run(5, 0, 0, 8'h00, 0);
    reset_dut();
    load(0, 8'h83);
    run(1, 0, 0, 8'h00, 0);
    run(0, 0, 0, 8'h00, 0);
    run(2, 1, 5, 8'h0E, 0);
    run(2, 0, 0, 8'h00, 1);
    load(4, 8'h3C);
    issue(3, 0, 0, 8'h00, tgt);
    repeat (30) @(negedge clk);
    nd = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_gen_count", 64'(gen_count), 64'd0);
    check_rows("abort", '0);
    repeat (300) @(negedge clk);
    chk("abort_no_done", 64'(n_done), 64'(nd));
    repeat (6) begin
      for (int r = 0; r < 8; r++) load(r, 8'($urandom_range(0, 255)));
      run($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gol_scheduler.md
GOL_SCHEDULER -- requirements
Module: gol_scheduler

Interface
REQ-001 SHALL have parameter GENS_W, default 8, width of generation count.
REQ-002 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port load_en, input, 1, write load_data into grid row load_row.
REQ-005 SHALL have port load_row, input, 3, row index for load.
REQ-006 SHALL have port load_data, input, 8, row contents; bit i = column i, 1 = alive.
REQ-007 SHALL have port start, input, 1, request a run of gens generations.
REQ-008 SHALL have port gens, input, GENS_W, generations to run, sampled on accepted start.
REQ-009 SHALL have port rd_row, input, 3, row index for readback.
REQ-010 SHALL have port rd_data, output, 8, combinational current-grid contents of rd_row.
REQ-011 SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at run completion.
REQ-013 SHALL have port gen_count, output, GENS_W, generations committed in current/last run.
REQ-014 SHALL have port pix_nbr, output, 8, neighbours of the cell under evaluation to the external pixel evaluator: bit0..7 = NW,N,NE,W,E,SW,S,SE.
REQ-015 SHALL have port pix_self, output, 1, current state of the cell under evaluation.
REQ-016 SHALL have port pix_next, input, 1, evaluator's next state for that cell, combinational, same cycle.

Function
REQ-017 SHALL hold an 8x8 current grid and an 8x8 next grid; the grid is a torus (row/column 7 neighbours row/column 0, modulo-8 index arithmetic).
REQ-018 SHALL implement states IDLE, EVAL, COMMIT, FIN.
REQ-019 In IDLE, SHALL write load_data to current-grid row load_row on a cycle with load_en=1; load_en SHALL be ignored in every other state.
REQ-020 In IDLE, on start=1, SHALL latch gens, clear gen_count to 0, clear the cell index, and go to EVAL if gens!=0, else to FIN.
REQ-021 When load_en and start are both high in IDLE, the load SHALL take effect and EVAL SHALL use the updated grid.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 In EVAL, SHALL evaluate one cell per cycle, cell index 0..63 row-major (row = idx[5:3], col = idx[2:0]), driving pix_nbr/pix_self from the current grid and writing pix_next into the next grid at that cell.
REQ-024 The current grid SHALL NOT change during EVAL; after index 63, SHALL go to COMMIT.
REQ-025 In COMMIT (1 cycle), SHALL copy the next grid to the current grid and increment gen_count; if the new gen_count equals latched gens, go to FIN, else reset the index and go to EVAL.
REQ-026 In FIN (1 cycle), SHALL assert done=1, then go to IDLE.
REQ-027 busy SHALL be 1 exactly in EVAL and COMMIT; done SHALL be 1 only in FIN.
REQ-028 A run of G>0 generations accepted at edge k SHALL assert done in cycle k+1+65*G; for G=0, in cycle k+1.
REQ-029 gen_count SHALL hold its final value in IDLE until the next accepted start.
REQ-030 pix_nbr and pix_self SHALL be 0 outside EVAL.
REQ-031 Outputs SHALL be registered except rd_data, pix_nbr and pix_self.

Reset
REQ-032 rst=1 SHALL, at the next rising edge, force IDLE, clear both grids, gen_count, the index, busy and done to 0, with priority over all other inputs.
REQ-033 Reset asserted mid-run SHALL abort the run with no done pulse.

Verification (bench evaluator: B3/S23 using pix_self and popcount of pix_nbr)
REQ-034 SHALL cover blinker: load row3=0x1C, others 0, start gens=1 -> done at start+66 cycles, rows 2,3,4 = 0x08, others 0, gen_count=1.
REQ-035 SHALL cover still life and gens>1: 2x2 block rows 1,2=0x06, gens=5 -> grid unchanged, gen_count=5, done at start+326, busy high for 325 cycles.
REQ-036 SHALL cover torus wrap: row0=0x83 (cols 7,0,1), gens=1 -> rows 7,0,1 = 0x01, all else 0.
REQ-037 SHALL cover gens=0: start -> done next cycle, busy never high, grid unchanged, gen_count=0.
REQ-038 SHALL cover ignored inputs: start and load_en during EVAL -> no restart, no grid write, done timing per REQ-028.
REQ-039 SHALL cover reset mid-run: rst at cycle 30 of EVAL -> IDLE, all rd_data=0, busy=0, no done pulse.
